// File: rtl/tone_mixer.sv
// Audio tone mixer: adds a square-wave tone of selectable pitch to each
// incoming stereo sample pair, saturating to the signed 32-bit range.
module tone_mixer #(
  parameter logic [31:0] AMPLITUDE = 32'd10000000,
  parameter logic [14:0] HALF_BASE = 15'd3000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [3:0]  period_sel,
  input  logic        audio_in_available,
  input  logic [31:0] left_in,
  input  logic [31:0] right_in,
  input  logic        audio_out_allowed,
  output logic        read_audio_in,
  output logic        write_audio_out,
  output logic [31:0] left_out,
  output logic [31:0] right_out
);

  typedef enum logic [1:0] {
    StIdle,
    StMix,
    StWaitOut
  } state_e;

  state_e      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic        snd_q, snd_d;
  logic [31:0] lat_l_q, lat_l_d;
  logic [31:0] lat_r_q, lat_r_d;
  logic [31:0] out_l_q, out_l_d;
  logic [31:0] out_r_q, out_r_d;
  logic [18:0] limit;
  logic [31:0] tone;
  logic        rd_c;
  logic        wr_c;

  // Signed add with clamping to the 32-bit two's complement range.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    unique case (sum[32:31])
      2'b01:   sat_add = 32'h7FFF_FFFF;
      2'b10:   sat_add = 32'h8000_0000;
      default: sat_add = sum[31:0];
    endcase
  endfunction

  assign limit = {period_sel, HALF_BASE};

  // Phase counter and tone bit; an over-limit count after a pitch change
  // restarts at 0 without toggling so it never runs through 2^19.
  always_comb begin
    cnt_d = cnt_q + 19'd1;
    snd_d = snd_q;
    if (period_sel == 4'd0) begin
      cnt_d = '0;
      snd_d = 1'b0;
    end else if (cnt_q == limit) begin
      cnt_d = '0;
      snd_d = ~snd_q;
    end else if (cnt_q > limit) begin
      cnt_d = '0;
    end
  end

  // Tone value: muted, or +/- amplitude depending on the square-wave phase.
  always_comb begin
    tone = '0;
    if (period_sel != 4'd0) begin
      tone = snd_q ? AMPLITUDE : (32'd0 - AMPLITUDE);
    end
  end

  // Handshake FSM: pop in IDLE, mix in MIX, push in WAIT_OUT.
  always_comb begin
    state_d = state_q;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    lat_l_d = lat_l_q;
    lat_r_d = lat_r_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    unique case (state_q)
      StIdle: begin
        if (audio_in_available) begin
          rd_c    = 1'b1;
          lat_l_d = left_in;
          lat_r_d = right_in;
          state_d = StMix;
        end
      end
      StMix: begin
        out_l_d = sat_add(lat_l_q, tone);
        out_r_d = sat_add(lat_r_q, tone);
        state_d = StWaitOut;
      end
      StWaitOut: begin
        wr_c = audio_out_allowed;
        if (audio_out_allowed) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register for counter, tone bit, FSM, latched inputs and outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      snd_q   <= 1'b0;
      lat_l_q <= '0;
      lat_r_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snd_q   <= snd_d;
      lat_l_q <= lat_l_d;
      lat_r_q <= lat_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
    end
  end

  // The pop strobe is combinational from IDLE, so mask it while reset is held.
  assign read_audio_in   = rd_c & resetn;
  assign write_audio_out = wr_c;
  assign left_out        = out_l_q;
  assign right_out       = out_r_q;

endmodule

// File: tb/tb_tone_mixer.sv
// Directed bench for tone_mixer: handshake timing, saturation, stall,
// reset abort and tone period/pitch-change behaviour.
module tb_tone_mixer;

  logic        clk;
  logic        resetn;
  logic [3:0]  period_sel;
  logic        avail;
  logic [31:0] left_in;
  logic [31:0] right_in;
  logic        allowed;
  logic        rd;
  logic        wr;
  logic [31:0] left_out;
  logic [31:0] right_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int both_cnt = 0;

  localparam logic [31:0] Amp    = 32'd10000000;
  localparam logic [31:0] NegAmp = 32'hFF67_6980;  // -10000000

  tone_mixer dut (
    .CLOCK_50           (clk),
    .resetn             (resetn),
    .period_sel         (period_sel),
    .audio_in_available (avail),
    .left_in            (left_in),
    .right_in           (right_in),
    .audio_out_allowed  (allowed),
    .read_audio_in      (rd),
    .write_audio_out    (wr),
    .left_out           (left_out),
    .right_out          (right_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop and push must never coincide.
  always @(negedge clk) if (rd && wr) both_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full transaction with audio_out_allowed high: pop, mix, push, idle.
  task automatic xfer(input string tag, input logic [31:0] l, input logic [31:0] r,
                      input logic [31:0] el, input logic [31:0] er);
    left_in  = l;
    right_in = r;
    avail    = 1'b1;
    allowed  = 1'b1;
    #1;
    check_eq({tag, "_pop"}, {31'd0, rd}, 32'd1);
    check_eq({tag, "_nopush0"}, {31'd0, wr}, 32'd0);
    step();
    avail = 1'b0;
    #1;
    check_eq({tag, "_mix_quiet"}, {30'd0, rd, wr}, 32'd0);
    step();
    check_eq({tag, "_push"}, {31'd0, wr}, 32'd1);
    check_eq({tag, "_left"}, left_out, el);
    check_eq({tag, "_right"}, right_out, er);
    step();
    check_eq({tag, "_idle"}, {31'd0, wr}, 32'd0);
  endtask

  initial begin
    int bad;
    int c0;
    resetn     = 1'b0;
    period_sel = 4'd0;
    avail      = 1'b1;
    allowed    = 1'b1;
    left_in    = 32'd5;
    right_in   = 32'd6;

    // Reset state, including the pop strobe masked despite avail=1.
    repeat (3) step();
    check_eq("rst_rd", {31'd0, rd}, 32'd0);
    check_eq("rst_wr", {31'd0, wr}, 32'd0);
    check_eq("rst_left", left_out, 32'd0);
    check_eq("rst_right", right_out, 32'd0);
    check_eq("rst_cnt", 32'(dut.cnt_q), 32'd0);
    check_eq("rst_snd", {31'd0, dut.snd_q}, 32'd0);
    avail  = 1'b0;
    resetn = 1'b1;
    step();

    // Muted tone passes samples through.
    xfer("pass", 32'd1234, 32'hFFFF_FFFB, 32'd1234, 32'hFFFF_FFFB);

    // Stall in WAIT_OUT for 50 cycles with a pending input pair.
    left_in  = 32'd7;
    right_in = 32'hFFFF_FFF8;
    avail    = 1'b1;
    allowed  = 1'b0;
    #1;
    check_eq("stall_pop", {31'd0, rd}, 32'd1);
    step();
    step();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (rd || wr || left_out != 32'd7 || right_out != 32'hFFFF_FFF8) bad++;
      step();
    end
    check_eq("stall_quiet", bad, 32'd0);
    allowed = 1'b1;
    #1;
    check_eq("stall_push", {31'd0, wr}, 32'd1);
    check_eq("stall_push_nopop", {31'd0, rd}, 32'd0);
    step();
    check_eq("stall_idle_pop", {31'd0, rd}, 32'd1);
    check_eq("stall_idle_nopush", {31'd0, wr}, 32'd0);
    avail = 1'b0;
    step();  // no pop taken: avail dropped before this edge

    // Reset while in WAIT_OUT discards the pair.
    left_in  = 32'd55;
    right_in = 32'd66;
    avail    = 1'b1;
    allowed  = 1'b0;
    step();
    avail = 1'b0;
    step();
    check_eq("wait_left", left_out, 32'd55);
    avail  = 1'b1;
    resetn = 1'b0;
    #1;
    check_eq("abort_rd", {31'd0, rd}, 32'd0);
    check_eq("abort_wr", {31'd0, wr}, 32'd0);
    check_eq("abort_left", left_out, 32'd0);
    check_eq("abort_right", right_out, 32'd0);
    step();
    step();
    resetn = 1'b1;
    xfer("after_rst", 32'd98, 32'd97, 32'd98, 32'd97);

    // Pitch change with counter above the new limit.
    period_sel = 4'd15;
    c0 = cyc;
    while (cyc - c0 < 35769) step();
    check_eq("cnt_hi", 32'(dut.cnt_q), 32'd35769);
    period_sel = 4'd1;
    step();
    check_eq("chg_cnt", 32'(dut.cnt_q), 32'd0);
    check_eq("chg_snd", {31'd0, dut.snd_q}, 32'd0);
    c0 = cyc;

    // snd=0: negative tone, right saturates low.
    xfer("neg", 32'd0, 32'h8000_0010, NegAmp, 32'h8000_0000);
    while (cyc - c0 < 35768) step();
    check_eq("pre_tgl_cnt", 32'(dut.cnt_q), 32'd35768);
    check_eq("pre_tgl_snd", {31'd0, dut.snd_q}, 32'd0);
    step();
    check_eq("tgl_cnt", 32'(dut.cnt_q), 32'd0);
    check_eq("tgl_snd", {31'd0, dut.snd_q}, 32'd1);

    // snd=1: positive tone, left saturates high.
    xfer("pos", 32'h7FFF_FF00, 32'd0, 32'h7FFF_FFFF, Amp);

    // Muting clears the counter and tone bit.
    period_sel = 4'd0;
    step();
    check_eq("mute_cnt", 32'(dut.cnt_q), 32'd0);
    check_eq("mute_snd", {31'd0, dut.snd_q}, 32'd0);
    check_eq("no_rd_wr_overlap", both_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_mixer.md
TONE_MIXER -- requirements
Module: tone_mixer

Interface
REQ-001 SHALL have parameter AMPLITUDE, default 32'd10000000, the tone magnitude added to each sample.
REQ-002 SHALL have parameter HALF_BASE, default 15'd3000, the low 15 bits of the half-period count.
REQ-003 SHALL have port CLOCK_50  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port period_sel  input  4  tone pitch select; 0 = tone muted.
REQ-006 SHALL have port audio_in_available  input  1  the audio controller holds an input sample pair.
REQ-007 SHALL have port left_in  input  32  signed left input sample.
REQ-008 SHALL have port right_in  input  32  signed right input sample.
REQ-009 SHALL have port audio_out_allowed  input  1  the audio controller output FIFO has space.
REQ-010 SHALL have port read_audio_in  output  1  one-cycle pop of the input sample pair.
REQ-011 SHALL have port write_audio_out  output  1  one-cycle push of the output sample pair.
REQ-012 SHALL have port left_out  output  32  signed mixed left sample, registered.
REQ-013 SHALL have port right_out  output  32  signed mixed right sample, registered.

Function
REQ-014 SHALL compute the half-period limit as {period_sel, HALF_BASE}, 19 bits.
REQ-015 SHALL increment the 19-bit phase counter every cycle; when the counter equals the limit it SHALL reset to 0 and toggle the tone bit snd.
REQ-016 SHALL reset the counter to 0 on the next cycle, without toggling snd, if the counter exceeds the limit after a period_sel change, so it never wraps through 2^19.
REQ-017 SHALL hold the counter at 0 and snd at 0 while period_sel == 0.
REQ-018 SHALL define tone = 0 if period_sel == 0; otherwise +AMPLITUDE if snd = 1, else -AMPLITUDE, as 32-bit two's complement.
REQ-019 SHALL implement an FSM with states IDLE, MIX and WAIT_OUT.
REQ-020 In IDLE, when audio_in_available = 1 the block SHALL drive read_audio_in = 1 for exactly that cycle, latch left_in and right_in, and go to MIX. Otherwise it SHALL stay in IDLE with read_audio_in = 0.
REQ-021 In MIX the block SHALL register left_out and right_out as the saturated sums of each latched sample plus the tone value sampled in that cycle, then go to WAIT_OUT.
REQ-022 Saturation SHALL use a 33-bit signed sum: results above 32'h7FFFFFFF clamp to 32'h7FFFFFFF, results below 32'h80000000 clamp to 32'h80000000.
REQ-023 In WAIT_OUT, write_audio_out SHALL equal audio_out_allowed. In the cycle it is 1 the block SHALL return to IDLE; otherwise it SHALL hold in WAIT_OUT with the outputs stable.
REQ-024 read_audio_in SHALL never be 1 outside IDLE, and write_audio_out SHALL never be 1 outside WAIT_OUT; both SHALL never be 1 in the same cycle.
REQ-025 Minimum pop-to-push latency SHALL be 2 cycles (pop in cycle N, push in cycle N+2), giving a maximum throughput of one sample pair per 3 cycles.
REQ-026 left_out and right_out SHALL change only in MIX.

Reset
REQ-027 While resetn = 0 the block SHALL force: state = IDLE, counter = 0, snd = 0, latched samples = 0, left_out = right_out = 0, read_audio_in = write_audio_out = 0.
REQ-028 Reset asserted in MIX or WAIT_OUT SHALL discard the pending pair with no push; after release, the first action SHALL be a pop only.

Verification
REQ-029 period_sel = 1, inputs held 0: snd SHALL toggle every 35769 cycles (limit 35768 + 1), and pushed samples SHALL alternate between +10000000 and -10000000.
REQ-030 period_sel = 0, left_in = 1234, right_in = -5: left_out SHALL be 1234 and right_out SHALL be -5, pushed 2 cycles after the pop.
REQ-031 left_in = 32'h7FFFFF00 with tone = +10000000 -> left_out SHALL be 32'h7FFFFFFF; right_in = 32'h80000010 with tone = -10000000 -> right_out SHALL be 32'h80000000.
REQ-032 audio_out_allowed held 0 for 50 cycles after MIX: the bench SHALL see no pop, no push and stable outputs; raising audio_out_allowed SHALL give exactly one push that cycle, then IDLE.
REQ-033 period_sel changed from 15 to 1 while the counter is 200000: the counter SHALL read 0 on the next cycle with snd unchanged.
REQ-034 resetn pulsed low in WAIT_OUT: all outputs SHALL be 0 immediately; with audio_in_available = 1 after release, the first handshake SHALL be a pop.
